icache_arb: RTL and testbench
=============================

# icache_arb

Two-requester arbiter for the single instruction-cache request port. It sits between the icache and two requesters: the fetch unit and the next-line prefetcher. It grants the port with fixed fetch priority plus anti-starvation for the prefetcher, and tracks the owner of every outstanding request so in-order icache responses are routed back to the right requester. On `rob_flush` it forwards the icache flush and squashes responses still in flight.

## Interface

Parameters:
- `DEPTH`, 2: maximum outstanding (accepted, unanswered) icache requests.
- `STARVE_LIMIT`, 4: consecutive fetch grants while the prefetcher waits before the prefetcher is forced a grant.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_arb_req`  in  1  fetch request valid.
- `fetch_arb_addr`  in  30 `[31:2]`  fetch word address.
- `arb_fetch_ready`  out  1  fetch request accepted this cycle.
- `arb_fetch_valid` / `arb_fetch_error`  out  1 / 1  response for fetch.
- `arb_fetch_data`  out  32  response data (equals `icache_data`).
- `pf_arb_req`  in  1  prefetch request valid.
- `pf_arb_addr`  in  30 `[31:2]`  prefetch word address.
- `arb_pf_ready`  out  1  prefetch request accepted this cycle.
- `arb_pf_valid` / `arb_pf_error`  out  1 / 1  response for prefetch.
- `arb_pf_data`  out  32  response data (equals `icache_data`).
- `arb_ic_req`  out  1  request to icache.
- `arb_ic_addr`  out  30 `[31:2]`  address of the granted requester.
- `arb_ic_flush`  out  1  icache flush.
- `icache_ready`, `icache_valid`, `icache_error`  in  1 each.
- `icache_data`  in  32  response data.
- `rob_flush`  in  1  pipeline flush.

## Operation

**State**
- Tag queue of `DEPTH` entries, each `{owner, squash}`.
- Occupancy count `0..DEPTH`.
- Starve counter `0..STARVE_LIMIT`.

**Grant (combinational)**
- `full = (count == DEPTH)`.
- `arb_ic_req = (fetch_arb_req | pf_arb_req) & ~full & ~rob_flush & ~rst`.
- Winner selection:
  - Prefetch wins if `pf_arb_req & (~fetch_arb_req | starve == STARVE_LIMIT)`.
  - Otherwise fetch wins.
- `arb_ic_addr` is the winner's address. It is 0 when there is no request.

**Accept**
- An accept occurs when `arb_ic_req & icache_ready`.
- On accept, the winner's ready output is 1 and the other requester's ready is 0.
- The queue pushes `{winner, 0}`.
- A full queue blocks issue even if a response pops in the same cycle (no bypass).

**Starve counter**
- Increments on a fetch accept while `pf_arb_req` = 1, saturating at `STARVE_LIMIT`.
- Clears on a prefetch accept, or in any cycle with `pf_arb_req` = 0.

**Response**
- On `icache_valid` with `count > 0`: pop the head entry.
- If `squash` = 0, assert the owner's valid and copy `icache_error` to the owner's error in the same cycle.
- If `squash` = 1, discard the response silently.
- `icache_valid` with `count == 0` is a protocol violation: ignore it, assert no valid, keep `count` at 0.
- Push and pop in the same cycle leave `count` unchanged.

**Flush**
- `arb_ic_flush = rob_flush` (combinational).
- Sets `squash` on every occupied entry, including an entry popped that same cycle, whose response is suppressed.
- No accept occurs in the flush cycle.
- Outstanding requests still drain normally afterwards; `count` is not cleared.

**Reset**
- Queue empty, `count` = 0, `starve` = 0.
- While `rst` = 1, every output is 0, including `arb_ic_flush`.
- A response arriving during reset is ignored.
- Reset mid-operation abandons all in-flight tags.

## Timing

- Request to icache: 0-cycle combinational pass-through from requester to `arb_ic_req`/`arb_ic_addr`. The ready outputs are valid in the same cycle.
- Response: 0-cycle combinational route from `icache_valid` to the owner's valid.
- State updates (queue, `count`, `starve`, `squash`) are visible in the cycle after the triggering edge.
- Responses return in request order; at most `DEPTH` are outstanding.
- Requesters must hold `req`/`addr` stable until their ready is 1.

## Structure

- Shared package holds:
  - owner encoding `OWN_FETCH` = 0, `OWN_PF` = 1;
  - tag entry typedef `{owner, squash}`;
  - address width constant (30).
- One sub-module, `arb_tagq`: a parameterised in-order tag FIFO with push, pop, squash-all, and `count`/`full`/`empty` outputs.
- Grant logic, starve counter and response routing live in `icache_arb`.

## Test plan

- **Reset:** hold `rst` 3 cycles with both requesters asserting and `icache_valid` = 1 → all outputs 0. First cycle after reset, `fetch_arb_req` with addr `0x100` → `arb_ic_addr` = `0x100` and `arb_fetch_ready` = 1.
- **Priority and starvation (`STARVE_LIMIT` = 4):** both requesters held continuously, `icache_ready` = 1, one response per cycle → grants F,F,F,F,P,F,F,F,F,P.
- **Full queue (`DEPTH` = 2):** two accepts with no response → third request sees `arb_ic_req` = 0. With a response in the same cycle there is still no accept; the next cycle accepts.
- **Flush squash:** accept F(`0x200`) then P(`0x204`), pulse `rob_flush` → `arb_ic_flush` = 1 that cycle and no accept. Both later responses produce no valid. A new F accept after that → valid with the data returned.
- **Routing and error:** accept P then F; respond with `icache_error` = 1 then 0 → `arb_pf_valid`/`arb_pf_error` = 1/1, then `arb_fetch_valid`/`arb_fetch_error` = 1/0, with data passed through unchanged.
- **Stray response:** `icache_valid` with an empty queue → no valid output and `count` stays 0.

Source files
------------

// File: rtl/icache_arb_pkg.sv
// Shared types and constants for the instruction-cache request arbiter.
package icache_arb_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_PF    = 1'b1;

    typedef struct packed {
        logic owner;
        logic squash;
    } tag_t;

endpackage

// File: rtl/arb_tagq.sv
// In-order tag FIFO recording the owner of each outstanding icache request.
module arb_tagq
    import icache_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  tag_t             push_tag,
    input  logic             pop,
    input  logic             squash_all,
    output tag_t             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    tag_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Squash marks every slot; free slots are rewritten whole on their next push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (squash_all) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem[i].squash <= 1'b1;
                end
            end
            if (push_ok) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_arb.sv
// Fetch/prefetch arbiter for the icache request port with in-order response routing.
module icache_arb
    import icache_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_arb_req,
    input  logic [ADDR_W-1:0] fetch_arb_addr,
    output logic              arb_fetch_ready,
    output logic              arb_fetch_valid,
    output logic              arb_fetch_error,
    output logic [DATA_W-1:0] arb_fetch_data,
    input  logic              pf_arb_req,
    input  logic [ADDR_W-1:0] pf_arb_addr,
    output logic              arb_pf_ready,
    output logic              arb_pf_valid,
    output logic              arb_pf_error,
    output logic [DATA_W-1:0] arb_pf_data,
    output logic              arb_ic_req,
    output logic [ADDR_W-1:0] arb_ic_addr,
    output logic              arb_ic_flush,
    input  logic              icache_ready,
    input  logic              icache_valid,
    input  logic              icache_error,
    input  logic [DATA_W-1:0] icache_data,
    input  logic              rob_flush
);

    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic [CNT_W-1:0]    q_count;
    logic                q_empty;
    logic                unused_full;
    tag_t                q_head;
    tag_t                push_tag;
    logic                full;
    logic                pf_win;
    logic                accept;
    logic                pop;
    logic                deliver;

    assign full   = (q_count == CNT_W'(DEPTH));
    assign pf_win = pf_arb_req & (~fetch_arb_req | (starve_q == STARVE_MAX));

    assign arb_ic_req      = (fetch_arb_req | pf_arb_req) & ~full & ~rob_flush & ~rst;
    assign arb_ic_addr     = !arb_ic_req ? '0 : (pf_win ? pf_arb_addr : fetch_arb_addr);
    assign accept          = arb_ic_req & icache_ready;
    assign arb_fetch_ready = accept & ~pf_win;
    assign arb_pf_ready    = accept & pf_win;
    assign arb_ic_flush    = rob_flush & ~rst;

    // A flush in the pop cycle suppresses that response as well.
    assign pop     = icache_valid & ~q_empty & ~rst;
    assign deliver = pop & ~q_head.squash & ~rob_flush;

    assign arb_fetch_valid = deliver & (q_head.owner == OWN_FETCH);
    assign arb_fetch_error = deliver & (q_head.owner == OWN_FETCH) & icache_error;
    assign arb_pf_valid    = deliver & (q_head.owner == OWN_PF);
    assign arb_pf_error    = deliver & (q_head.owner == OWN_PF) & icache_error;
    assign arb_fetch_data  = rst ? '0 : icache_data;
    assign arb_pf_data     = rst ? '0 : icache_data;

    assign push_tag = '{owner: (pf_win ? OWN_PF : OWN_FETCH), squash: 1'b0};

    // Starvation counts fetch wins only while the prefetcher keeps waiting.
    always_comb begin
        starve_d = starve_q;
        if (!pf_arb_req) begin
            starve_d = '0;
        end else if (accept && pf_win) begin
            starve_d = '0;
        end else if (accept && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    arb_tagq #(
        .DEPTH (DEPTH)
    ) u_tagq (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_tag   (push_tag),
        .pop        (pop),
        .squash_all (arb_ic_flush),
        .head       (q_head),
        .count      (q_count),
        .full       (unused_full),
        .empty      (q_empty)
    );

endmodule

// File: tb/tb_icache_arb.sv
// Directed table plus randomized checking of icache_arb against a queue-based model.
module tb_icache_arb;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        rst;
        logic        freq;
        logic [29:0] faddr;
        logic        preq;
        logic [29:0] paddr;
        logic        ic_ready;
        logic        ic_valid;
        logic        ic_error;
        logic [31:0] ic_data;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic        ic_req;
        logic [29:0] ic_addr;
        logic        f_ready;
        logic        p_ready;
        logic        f_valid;
        logic        f_error;
        logic        p_valid;
        logic        p_error;
        logic [31:0] f_data;
        logic [31:0] p_data;
        logic        ic_flush;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_arb_req;
    logic [29:0] fetch_arb_addr;
    logic        arb_fetch_ready;
    logic        arb_fetch_valid;
    logic        arb_fetch_error;
    logic [31:0] arb_fetch_data;
    logic        pf_arb_req;
    logic [29:0] pf_arb_addr;
    logic        arb_pf_ready;
    logic        arb_pf_valid;
    logic        arb_pf_error;
    logic [31:0] arb_pf_data;
    logic        arb_ic_req;
    logic [29:0] arb_ic_addr;
    logic        arb_ic_flush;
    logic        icache_ready;
    logic        icache_valid;
    logic        icache_error;
    logic [31:0] icache_data;
    logic        rob_flush;

    int nvec = 0;
    int nmis = 0;

    // Reference state: outstanding owners (0 fetch, 1 prefetch) with squash marks.
    int q_own [$];
    bit q_sq  [$];
    int starve = 0;

    row_t tbl [$];

    always #5 clk = ~clk;

    icache_arb #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_arb_req   (fetch_arb_req),
        .fetch_arb_addr  (fetch_arb_addr),
        .arb_fetch_ready (arb_fetch_ready),
        .arb_fetch_valid (arb_fetch_valid),
        .arb_fetch_error (arb_fetch_error),
        .arb_fetch_data  (arb_fetch_data),
        .pf_arb_req      (pf_arb_req),
        .pf_arb_addr     (pf_arb_addr),
        .arb_pf_ready    (arb_pf_ready),
        .arb_pf_valid    (arb_pf_valid),
        .arb_pf_error    (arb_pf_error),
        .arb_pf_data     (arb_pf_data),
        .arb_ic_req      (arb_ic_req),
        .arb_ic_addr     (arb_ic_addr),
        .arb_ic_flush    (arb_ic_flush),
        .icache_ready    (icache_ready),
        .icache_valid    (icache_valid),
        .icache_error    (icache_error),
        .icache_data     (icache_data),
        .rob_flush       (rob_flush)
    );

    function automatic in_t mk_i(logic r, logic fr, logic [29:0] fa, logic pr, logic [29:0] pa,
                                 logic rdy, logic v, logic e, logic [31:0] d, logic fl);
        in_t x;
        x.rst = r; x.freq = fr; x.faddr = fa; x.preq = pr; x.paddr = pa;
        x.ic_ready = rdy; x.ic_valid = v; x.ic_error = e; x.ic_data = d; x.flush = fl;
        return x;
    endfunction

    function automatic out_t mk_o(logic req, logic [29:0] a, logic frdy, logic prdy, logic fv,
                                  logic fe, logic pv, logic pe, logic [31:0] d, logic fl);
        out_t x;
        x.ic_req = req; x.ic_addr = a; x.f_ready = frdy; x.p_ready = prdy;
        x.f_valid = fv; x.f_error = fe; x.p_valid = pv; x.p_error = pe;
        x.f_data = d; x.p_data = d; x.ic_flush = fl;
        return x;
    endfunction

    task automatic row(input string n, input in_t i, input out_t o);
        row_t r;
        r.name = n; r.i = i; r.o = o;
        tbl.push_back(r);
    endtask

    // Drive one cycle, check against the model (and the hand value if given), then advance.
    task automatic apply(input in_t vi, input bit has_exp, input out_t ve, input string name);
        out_t me;
        out_t act;
        bit   full;
        bit   req;
        bit   pfw;
        bit   acc;
        rst            = vi.rst;
        fetch_arb_req  = vi.freq;
        fetch_arb_addr = vi.faddr;
        pf_arb_req     = vi.preq;
        pf_arb_addr    = vi.paddr;
        icache_ready   = vi.ic_ready;
        icache_valid   = vi.ic_valid;
        icache_error   = vi.ic_error;
        icache_data    = vi.ic_data;
        rob_flush      = vi.flush;
        #1;
        me  = '0;
        acc = 1'b0;
        pfw = 1'b0;
        if (!vi.rst) begin
            full = (q_own.size() >= DEPTH);
            req  = (vi.freq || vi.preq) && !full && !vi.flush;
            pfw  = vi.preq && (!vi.freq || starve == STARVE_LIMIT);
            acc  = req && vi.ic_ready;
            me.ic_req   = req;
            me.ic_addr  = req ? (pfw ? vi.paddr : vi.faddr) : 30'h0;
            me.f_ready  = acc && !pfw;
            me.p_ready  = acc && pfw;
            me.f_data   = vi.ic_data;
            me.p_data   = vi.ic_data;
            me.ic_flush = vi.flush;
            if (vi.ic_valid && q_own.size() > 0 && !q_sq[0] && !vi.flush) begin
                if (q_own[0] == 0) begin
                    me.f_valid = 1'b1;
                    me.f_error = vi.ic_error;
                end else begin
                    me.p_valid = 1'b1;
                    me.p_error = vi.ic_error;
                end
            end
        end
        act.ic_req   = arb_ic_req;
        act.ic_addr  = arb_ic_addr;
        act.f_ready  = arb_fetch_ready;
        act.p_ready  = arb_pf_ready;
        act.f_valid  = arb_fetch_valid;
        act.f_error  = arb_fetch_error;
        act.p_valid  = arb_pf_valid;
        act.p_error  = arb_pf_error;
        act.f_data   = arb_fetch_data;
        act.p_data   = arb_pf_data;
        act.ic_flush = arb_ic_flush;
        nvec++;
        if (act !== me) begin
            nmis++;
            $display("FAIL %s (model) got=%h expected=%h", name, act, me);
        end
        if (has_exp) begin
            nvec++;
            if (act !== ve) begin
                nmis++;
                $display("FAIL %s (table) got=%h expected=%h", name, act, ve);
            end
        end
        @(posedge clk);
        if (vi.rst) begin
            q_own.delete();
            q_sq.delete();
            starve = 0;
        end else begin
            if (vi.ic_valid && q_own.size() > 0) begin
                void'(q_own.pop_front());
                void'(q_sq.pop_front());
            end
            if (vi.flush) begin
                foreach (q_sq[k]) q_sq[k] = 1'b1;
            end
            if (acc) begin
                q_own.push_back(pfw ? 1 : 0);
                q_sq.push_back(1'b0);
            end
            if (!vi.preq || (acc && pfw)) starve = 0;
            else if (acc && starve < STARVE_LIMIT) starve++;
        end
        #1;
    endtask

    initial begin
        in_t  ri;
        out_t z;
        z = '0;

        // Reset held with both requesters and a response present.
        for (int k = 0; k < 3; k++)
            row("reset", mk_i(1, 1, 30'h100, 1, 30'h200, 1, 1, 1, 32'hdead_beef, 1), z);
        row("post_reset_fetch", mk_i(0, 1, 30'h100, 0, 30'h0, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h100, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        row("post_reset_resp", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h11, 0),
            mk_o(0, 30'h0, 0, 0, 1, 0, 0, 0, 32'h11, 0));

        // Starvation: grants F,F,F,F,P,F,F,F,F,P with one response per cycle after the first.
        row("starve_1", mk_i(0, 1, 30'h300, 1, 30'h400, 1, 0, 0, 32'h1001, 0),
            mk_o(1, 30'h300, 1, 0, 0, 0, 0, 0, 32'h1001, 0));
        for (int k = 2; k <= 10; k++) begin
            bit p_grant;
            bit p_resp;
            p_grant = (k == 5) || (k == 10);
            p_resp  = (k == 6);
            row($sformatf("starve_%0d", k),
                mk_i(0, 1, 30'h300, 1, 30'h400, 1, 1, 0, 32'h1000 + 32'(k), 0),
                mk_o(1, p_grant ? 30'h400 : 30'h300, !p_grant, p_grant,
                     !p_resp, 0, p_resp, 0, 32'h1000 + 32'(k), 0));
        end
        row("starve_drain", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h100b, 0),
            mk_o(0, 30'h0, 0, 0, 0, 0, 1, 0, 32'h100b, 0));

        // Full queue blocks issue, even when a response pops that cycle.
        row("full_acc1", mk_i(0, 1, 30'h500, 0, 30'h0, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h500, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        row("full_acc2", mk_i(0, 1, 30'h500, 0, 30'h0, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h500, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        row("full_block", mk_i(0, 1, 30'h504, 0, 30'h0, 1, 0, 0, 32'h0, 0), z);
        row("full_nobypass", mk_i(0, 1, 30'h504, 0, 30'h0, 1, 1, 0, 32'h21, 0),
            mk_o(0, 30'h0, 0, 0, 1, 0, 0, 0, 32'h21, 0));
        row("full_accept", mk_i(0, 1, 30'h504, 0, 30'h0, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h504, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        for (int k = 0; k < 2; k++)
            row("full_drain", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h22, 0),
                mk_o(0, 30'h0, 0, 0, 1, 0, 0, 0, 32'h22, 0));

        // Flush squashes outstanding responses and blocks accept that cycle.
        row("flush_accF", mk_i(0, 1, 30'h200, 0, 30'h0, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h200, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        row("flush_accP", mk_i(0, 0, 30'h0, 1, 30'h204, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h204, 0, 1, 0, 0, 0, 0, 32'h0, 0));
        row("flush_pulse", mk_i(0, 1, 30'h208, 0, 30'h0, 1, 0, 0, 32'h0, 1),
            mk_o(0, 30'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
        row("flush_sq1", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h31, 0),
            mk_o(0, 30'h0, 0, 0, 0, 0, 0, 0, 32'h31, 0));
        row("flush_sq2", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h32, 0),
            mk_o(0, 30'h0, 0, 0, 0, 0, 0, 0, 32'h32, 0));
        row("flush_newF", mk_i(0, 1, 30'h208, 0, 30'h0, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h208, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        row("flush_newresp", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'hcafe, 0),
            mk_o(0, 30'h0, 0, 0, 1, 0, 0, 0, 32'hcafe, 0));
        row("flush_popacc", mk_i(0, 1, 30'h20c, 0, 30'h0, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h20c, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        row("flush_samepop", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h33, 1),
            mk_o(0, 30'h0, 0, 0, 0, 0, 0, 0, 32'h33, 1));

        // Routing and error: P then F, responses error=1 then 0.
        row("route_accP", mk_i(0, 0, 30'h0, 1, 30'h600, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h600, 0, 1, 0, 0, 0, 0, 32'h0, 0));
        row("route_accF", mk_i(0, 1, 30'h604, 0, 30'h0, 1, 0, 0, 32'h0, 0),
            mk_o(1, 30'h604, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        row("route_respP", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 1, 32'haaaa_5555, 0),
            mk_o(0, 30'h0, 0, 0, 0, 0, 1, 1, 32'haaaa_5555, 0));
        row("route_respF", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h1234_5678, 0),
            mk_o(0, 30'h0, 0, 0, 1, 0, 0, 0, 32'h1234_5678, 0));

        // Stray response; then exactly DEPTH accepts fill the queue.
        row("stray", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 1, 32'h44, 0),
            mk_o(0, 30'h0, 0, 0, 0, 0, 0, 0, 32'h44, 0));
        for (int k = 0; k < 2; k++)
            row("stray_acc", mk_i(0, 1, 30'h700, 0, 30'h0, 1, 0, 0, 32'h0, 0),
                mk_o(1, 30'h700, 1, 0, 0, 0, 0, 0, 32'h0, 0));
        row("stray_full", mk_i(0, 1, 30'h700, 0, 30'h0, 1, 0, 0, 32'h0, 0), z);

        // Reset mid-operation abandons in-flight tags.
        row("midrst", mk_i(1, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h55, 0), z);
        row("midrst_stray", mk_i(0, 0, 30'h0, 0, 30'h0, 1, 1, 0, 32'h56, 0),
            mk_o(0, 30'h0, 0, 0, 0, 0, 0, 0, 32'h56, 0));

        rst = 1'b1;
        fetch_arb_req = 0; fetch_arb_addr = '0; pf_arb_req = 0; pf_arb_addr = '0;
        icache_ready = 0; icache_valid = 0; icache_error = 0; icache_data = '0; rob_flush = 0;
        @(posedge clk);
        #1;

        foreach (tbl[k]) apply(tbl[k].i, 1'b1, tbl[k].o, tbl[k].name);

        for (int k = 0; k < 3000; k++) begin
            ri.rst      = ($urandom_range(0, 63) == 0);
            ri.freq     = ($urandom_range(0, 2) != 0);
            ri.faddr    = 30'($urandom());
            ri.preq     = ($urandom_range(0, 1) != 0);
            ri.paddr    = 30'($urandom());
            ri.ic_ready = ($urandom_range(0, 3) != 0);
            ri.ic_valid = ($urandom_range(0, 1) != 0);
            ri.ic_error = ($urandom_range(0, 3) == 0);
            ri.ic_data  = $urandom();
            ri.flush    = ($urandom_range(0, 11) == 0);
            apply(ri, 1'b0, z, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
